dmem_responder: RTL and testbench

Data-memory responder serving the load/store requests issued by the MIPS datapath (address from `ALUOut`, store data from `WriteData`, load data returned as `ReadData`). It holds a word-addressed on-chip RAM, accepts one request at a time over a valid/ready handshake, and inserts a programmable number of wait states. It returns each result on a response channel that is held until consumed. Misaligned or out-of-range accesses complete with an error flag and never modify memory.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MIPS datapath (master) and the data-memory
// responder (slave): valid/ready request channel plus a held response channel.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with one outstanding request, programmable wait states
// and a held response. Optional macro DMEM_BYTE_EN enables per-byte store masking.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clka,
  input logic            rst,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
`ifdef DMEM_BYTE_EN
  logic [3:0]    be_q;
`endif
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic          align_ok;
  logic          in_range;
  logic          acc_err;
  logic [3:0]    wmask;
  logic [AW-1:0] idx;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign commit   = (state == WAIT) && (cnt == '0);
  assign idx      = addr_q[AW+1:2];
  assign in_range = addr_q[31:2] < 30'(DEPTH_WORDS);
  assign acc_err  = !align_ok || !in_range;

  always_comb begin
    align_ok = 1'b0;
    wmask    = '1;
`ifdef DMEM_BYTE_EN
    wmask = be_q;
    case (be_q)
      4'b1111:                            align_ok = (addr_q[1:0] == 2'b00);
      4'b0011, 4'b1100:                   align_ok = !addr_q[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000: align_ok = 1'b1;
      4'b0000:                            align_ok = 1'b1;
      default:                            align_ok = 1'b0;
    endcase
`else
    align_ok = (addr_q[1:0] == 2'b00);
`endif
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // WAIT always runs WAIT_CYCLES+1 cycles (counter starts at WAIT_CYCLES and exits
  // on 0), so the response appears WAIT_CYCLES+1 edges after acceptance, W=0 included.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef DMEM_BYTE_EN
      be_q    <= '0;
`endif
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
`ifdef DMEM_BYTE_EN
        be_q    <= bus.req_be;
`endif
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (we_q || acc_err) ? '0 : mem[idx];
      end
    end
  end

  // RAM is deliberately outside the reset domain; commit is low while reset is held.
  always_ff @(posedge clka) begin
    if (commit && we_q && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, handshake/reset
// sequences and randomized traffic checked against a behavioural memory model.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clka (clk),
    .rst  (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mdl [DEPTH];

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: decide error from alignment/range, then read or update words.
  task automatic model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output bit er);
    int unsigned w;
    bit mis;
    w  = a >> 2;
`ifdef DMEM_BYTE_EN
    if (be == 4'hF)                      mis = (a % 4) != 0;
    else if (be == 4'h3 || be == 4'hC)   mis = (a % 2) != 0;
    else if ($countones(be) <= 1)        mis = 1'b0;
    else                                 mis = 1'b1;
`else
    mis = (a % 4) != 0;
`endif
    er = mis || (w >= DEPTH);
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_BYTE_EN
          if (be[i]) mdl[w][8*i +: 8] = wd[8*i +: 8];
`else
          mdl[w][8*i +: 8] = wd[8*i +: 8];
`endif
        end
      end else begin
        rd = mdl[w];
      end
    end
  endtask

  task automatic txn(input string name, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     input logic [31:0] exp_rdata, input bit exp_err);
    int lat;
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check({name, "_req_ready_timeout"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check({name, "_busy_after_accept"}, 32'(bus.req_ready), 32'd0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.resp_valid) break;
    end
    check({name, "_latency"}, 32'(lat), 32'(WAITC + 1));
    check({name, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({name, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check({name, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      check({name, "_hold_rdata"}, bus.resp_rdata, exp_rdata);
      check({name, "_hold_err"}, 32'(bus.resp_err), 32'(exp_err));
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({name, "_resp_drop"}, 32'(bus.resp_valid), 32'd0);
    check({name, "_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] erd;
    bit          eer;
    logic [3:0]  be_list [10];
    n_checks = 0;
    n_fail   = 0;
    be_list  = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h0, 4'h6, 4'h5};
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;

    vq.push_back('{"st_beef",   1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0});
    vq.push_back('{"ld_beef",   1'b0, 32'h10,       32'h0,        4'hF, 5, 32'hDEADBEEF, 1'b0});
    vq.push_back('{"ld_mis",    1'b0, 32'h12,       32'h0,        4'hF, 0, 32'h0,        1'b1});
    vq.push_back('{"ld_after",  1'b0, 32'h10,       32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0});
    vq.push_back('{"st_mis",    1'b1, 32'h11,       32'h99999999, 4'hF, 0, 32'h0,        1'b1});
    vq.push_back('{"ld_untch",  1'b0, 32'h10,       32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0});
    vq.push_back('{"ld_oor",    1'b0, 32'h1000,     32'h0,        4'hF, 0, 32'h0,        1'b1});
    vq.push_back('{"st_oor",    1'b1, 32'h1000,     32'h12345678, 4'hF, 0, 32'h0,        1'b1});
    vq.push_back('{"ld_w0",     1'b0, 32'h0,        32'h0,        4'hF, 0, 32'h0,        1'b0});
    vq.push_back('{"st_last",   1'b1, 32'hFFC,      32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0});
    vq.push_back('{"ld_last",   1'b0, 32'hFFC,      32'h0,        4'hF, 1, 32'hCAFEF00D, 1'b0});
    vq.push_back('{"ld_high",   1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 0, 32'h0,        1'b1});
`ifdef DMEM_BYTE_EN
    vq.push_back('{"st_full",   1'b1, 32'h20,       32'h11223344, 4'hF, 0, 32'h0,        1'b0});
    vq.push_back('{"st_b0",     1'b1, 32'h20,       32'h000000AA, 4'h1, 0, 32'h0,        1'b0});
    vq.push_back('{"ld_merge",  1'b0, 32'h20,       32'h0,        4'hF, 0, 32'h112233AA, 1'b0});
    vq.push_back('{"st_be0",    1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 0, 32'h0,        1'b0});
    vq.push_back('{"st_be6",    1'b1, 32'h20,       32'hFFFFFFFF, 4'h6, 0, 32'h0,        1'b1});
    vq.push_back('{"st_half",   1'b1, 32'h22,       32'h0000BEEF, 4'h3, 0, 32'h0,        1'b0});
    vq.push_back('{"ld_half",   1'b0, 32'h20,       32'h0,        4'hF, 0, 32'h1122BEEF, 1'b0});
    vq.push_back('{"ld_mis22",  1'b0, 32'h22,       32'h0,        4'hF, 0, 32'h0,        1'b1});
`else
    vq.push_back('{"st_be_ign", 1'b1, 32'h20,       32'h11223344, 4'h1, 0, 32'h0,        1'b0});
    vq.push_back('{"ld_be_ign", 1'b0, 32'h20,       32'h0,        4'hF, 0, 32'h11223344, 1'b0});
`endif

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_be     = '0;
    bus.resp_ready = 1'b0;
    rst_n          = 1'b0;
    #12;
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata,      32'd0);
    check("rst_resp_err",   32'(bus.resp_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAM power-up contents are not guaranteed, so the low 64 words are cleared first.
    for (int w = 0; w < 64; w++) txn("clr", 1'b1, 32'(w * 4), 32'h0, 4'hF, 0, 32'h0, 1'b0);

    foreach (vq[i]) begin
      model(vq[i].we, vq[i].addr, vq[i].wdata, vq[i].be, erd, eer);
      txn(vq[i].name, vq[i].we, vq[i].addr, vq[i].wdata, vq[i].be, vq[i].hold,
          vq[i].exp_rdata, vq[i].exp_err);
    end

    // Reset one cycle after accepting a store: store dropped, outputs cleared.
    txn("pre_rst_ld", 1'b0, 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h55;
    bus.req_be    = 4'hF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("mid_busy", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_resp_rdata", bus.resp_rdata,      32'd0);
    check("mid_rst_resp_err",   32'(bus.resp_err),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn("ld_dropped", 1'b0, 32'h30, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    txn("ld_kept",    1'b0, 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0);

    for (int n = 0; n < 150; n++) begin
      bit          we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      int          hold;
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      hold = int'($urandom_range(0, 3));
`ifdef DMEM_BYTE_EN
      be   = be_list[$urandom_range(0, 9)];
`else
      be   = 4'($urandom);
`endif
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        1:       a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        default: a = 32'($urandom_range(0, 63) * 4);
      endcase
      model(we, a, wd, be, erd, eer);
      txn("rand", we, a, wd, be, hold, erd, eer);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
